// File: rtl/fac_pipe.sv
// Shared-factor expander for the masked Canright S-box: per-share GF(2^4)
// factor sums, registered through a 2-entry valid/ready buffer.
module fac_pipe #(
    parameter int SHARES = 2,
    parameter bit WIDE   = 1'b0,
    localparam int IW    = WIDE ? 8 : 4,
    localparam int OW    = WIDE ? 27 : 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SHARES*IW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SHARES*OW-1:0] out_data,
    output logic [1:0]           count
);

    function automatic logic [8:0] nibFactor(input logic [3:0] n);
        logic [1:0] s;
        s = n[3:2] ^ n[1:0];
        return {s[1] ^ s[0], s, n[3] ^ n[2], n[3:2], n[1] ^ n[0], n[1:0]};
    endfunction

    logic [SHARES*OW-1:0] word;

    // Each share is expanded on its own; no bits cross share boundaries.
    for (genvar k = 0; k < SHARES; k++) begin : g_share
        if (WIDE) begin : g_wide
            logic [7:0] b;
            assign b = in_data[k*IW +: 8];
            assign word[k*OW +: OW] = {nibFactor(b[7:4] ^ b[3:0]),
                                       nibFactor(b[7:4]),
                                       nibFactor(b[3:0])};
        end else begin : g_narrow
            assign word[k*OW +: OW] = nibFactor(in_data[k*IW +: 4]);
        end
    end

    logic [SHARES*OW-1:0] mem_q [2];
    logic [SHARES*OW-1:0] data_q, data_d;
    logic                 wrPtr_q, wrPtr_d;
    logic                 rdPtr_q, rdPtr_d;
    logic [1:0]           count_q, count_d;
    logic                 push, pop;

    assign in_ready  = !clr && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q;
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !clr;

    // The head is kept in its own register so it holds its last value once
    // the buffer drains instead of showing a stale slot.
    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q ^ pop;
        wrPtr_d = wrPtr_q ^ push;
        data_d  = data_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (clr) begin
            count_d = 2'd0;
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
        end else if (count_d != 2'd0) begin
            data_d = (push && (wrPtr_q == rdPtr_d)) ? word : mem_q[rdPtr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            data_q   <= '0;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= word;
            end
            data_q  <= data_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fac_pipe.sv
// Bench for fac_pipe: queue-based reference model with a per-cycle compare
// process, plus directed literal checks on narrow and wide instances.
module tb_fac_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [17:0] out_data;
    logic [1:0]  count;

    logic        wValid = 1'b0;
    logic        wClr = 1'b0;
    logic        wOutReady = 1'b1;
    logic [7:0]  wData = 8'h00;
    logic        wReady;
    logic        wOutValid;
    logic [26:0] wOut;
    logic [1:0]  wCount;

    int total = 0;
    int bad = 0;

    logic [17:0] modelQ[$];
    logic [17:0] modelLast = 18'h0;

    always #5 clk = ~clk;

    fac_pipe #(.SHARES(2), .WIDE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    fac_pipe #(.SHARES(1), .WIDE(1'b1)) dutWide (
        .clk(clk), .rst_n(rst_n), .clr(wClr),
        .in_valid(wValid), .in_ready(wReady), .in_data(wData),
        .out_valid(wOutValid), .out_ready(wOutReady), .out_data(wOut),
        .count(wCount)
    );

    // Factor sums from arithmetic on the two 2-bit halves of a nibble.
    function automatic int nf(input int n);
        int hi, lo, s;
        hi = (n >> 2) & 3;
        lo = n & 3;
        s  = hi ^ lo;
        return (((s >> 1) ^ s) & 1) << 8 | s << 6 |
               (((hi >> 1) ^ hi) & 1) << 5 | hi << 3 |
               (((lo >> 1) ^ lo) & 1) << 2 | lo;
    endfunction

    function automatic logic [17:0] expandNarrow(input logic [7:0] d);
        int v;
        v = (nf(int'(d) >> 4) << 9) | nf(int'(d) & 15);
        return v[17:0];
    endfunction

    function automatic logic [26:0] expandWide(input logic [7:0] d);
        int hi, lo, v;
        hi = int'(d) >> 4;
        lo = int'(d) & 15;
        v  = (nf(hi ^ lo) << 18) | (nf(hi) << 9) | nf(lo);
        return v[26:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clr       = c;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: a bounded queue of expanded words.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                modelQ.delete();
                modelLast = 18'h0;
            end else begin
                bit doPush, doPop;
                doPush = in_valid && !clr && (modelQ.size() < 2);
                doPop  = (modelQ.size() > 0) && out_ready && !clr;
                if (clr) begin
                    modelQ.delete();
                end else begin
                    if (doPop) void'(modelQ.pop_front());
                    if (doPush) modelQ.push_back(expandNarrow(in_data));
                end
                if (modelQ.size() > 0) modelLast = modelQ[0];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("mdl_out_valid", 32'(out_valid), 32'(modelQ.size() != 0));
                checkOutput("mdl_count", 32'(count), 32'(modelQ.size()));
                checkOutput("mdl_in_ready", 32'(in_ready), 32'(!clr && modelQ.size() != 2));
                checkOutput("mdl_out_data", 32'(out_data), 32'(modelLast));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [17:0] exp18;
        logic [7:0]  b;

        repeat (2) step();
        rst_n = 1'b1;
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);

        applyStimulus(1'b1, 8'hF6, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        exp18 = {9'h01B, 9'h0EE};
        checkOutput("f6_valid", 32'(out_valid), 32'd1);
        checkOutput("f6_data", 32'(out_data), 32'(exp18));
        checkOutput("f6_count", 32'(count), 32'd1);
        step();
        checkOutput("f6_drain", 32'(count), 32'd0);

        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
        checkOutput("stream0", 32'(out_data), 32'd0);
        step();
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        exp18 = {9'h145, 9'h145};
        checkOutput("stream1", 32'(out_data), 32'(exp18));
        checkOutput("stream1_valid", 32'(out_valid), 32'd1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        exp18 = {9'h036, 9'h036};
        checkOutput("streamA", 32'(out_data), 32'(exp18));
        checkOutput("streamA_count", 32'(count), 32'd1);
        step();

        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("bp_count1", 32'(count), 32'd1);
        step();
        applyStimulus(1'b1, 8'h96, 1'b0, 1'b0);
        checkOutput("bp_count2", 32'(count), 32'd2);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        step();
        checkOutput("bp_head_stable", 32'(out_data), 32'(expandNarrow(8'h3C)));
        out_ready = 1'b1;
        step();
        checkOutput("bp_pop1_head", 32'(out_data), 32'(expandNarrow(8'h5A)));
        checkOutput("bp_pop1_count", 32'(count), 32'd1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bp_third_head", 32'(out_data), 32'(expandNarrow(8'h96)));
        checkOutput("bp_pushpop_count", 32'(count), 32'd1);
        step();
        checkOutput("bp_empty", 32'(count), 32'd0);

        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h56, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("clr_count", 32'(count), 32'd0);
        checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
        step();
        checkOutput("clr_not_captured", 32'(count), 32'd0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            step();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) step();

        wValid = 1'b1;
        wData  = 8'h1F;
        step();
        checkOutput("wide_1f", 32'(wOut), 32'h057A8A1B);
        checkOutput("wide_valid", 32'(wOutValid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            wData = b;
            step();
            checkOutput("wide_rand", 32'(wOut), 32'(expandWide(b)));
        end
        wValid = 1'b0;
        step();
        checkOutput("wide_drain", 32'(wCount), 32'd0);

        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_out_data", 32'(out_data), 32'd0);
        checkOutput("arst_count", 32'(count), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
